// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO control slice: default geometry and FSM state encodings.
package fifo_pkg;

    localparam int unsigned DepthDef    = 8;
    localparam int unsigned PtrWidthDef = 8;
    localparam int unsigned CntWidthDef = 4;

    typedef logic [2:0] state_t;

    localparam state_t StReset  = 3'd0;
    localparam state_t StInit   = 3'd1;
    localparam state_t StIdle   = 3'd2;
    localparam state_t StActive = 3'd3;
    localparam state_t StError  = 3'd4;

endpackage

// File: rtl/fifo_if.sv
// Request/status bundle between a FIFO user (master) and fifo_ctrl (slave).
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int unsigned PTR_WIDTH = PtrWidthDef,
    parameter int unsigned CNT_WIDTH = CntWidthDef
);
    logic                 init;
    logic [CNT_WIDTH-1:0] th_low;
    logic [CNT_WIDTH-1:0] th_high;
    logic                 push;
    logic                 pop;
    logic                 wr_enable;
    logic                 rd_enable;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 overflow_err;
    logic                 underflow_err;
    state_t               state;

    modport master (
        output init, th_low, th_high, push, pop,
        input  wr_enable, rd_enable, wr_ptr, rd_ptr, count, full, empty,
               almost_full, almost_empty, overflow_err, underflow_err, state
    );

    modport slave (
        input  init, th_low, th_high, push, pop,
        output wr_enable, rd_enable, wr_ptr, rd_ptr, count, full, empty,
               almost_full, almost_empty, overflow_err, underflow_err, state
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping address register: advances on en_i, wraps DEPTH-1 -> 0, flush_i forces it to 0.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = DepthDef,
    parameter int unsigned PTR_WIDTH = PtrWidthDef
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic                 flush_i,
    output logic [PTR_WIDTH-1:0] ptr_o
);

    logic [PTR_WIDTH-1:0] ptr_d, ptr_q;

    // Explicit wrap compare so non-power-of-two depths work.
    always_comb begin
        ptr_d = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = (ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr_q + PTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage: gates push/pop into array enables, tracks occupancy, flags and
// sticky errors, and sequences RESET/INIT/IDLE/ACTIVE/ERROR.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH       = DepthDef,
    parameter int unsigned PTR_WIDTH   = PtrWidthDef,
    parameter int unsigned CNT_WIDTH   = CntWidthDef,
    parameter int unsigned TH_LOW_DEF  = 1,
    parameter int unsigned TH_HIGH_DEF = 7
) (
    input logic   clk,
    input logic   reset,
    fifo_if.slave bus
);

    state_t               state_d, state_q;
    logic [CNT_WIDTH-1:0] count_d, count_q;
    logic [CNT_WIDTH-1:0] th_low_d, th_low_q;
    logic [CNT_WIDTH-1:0] th_high_d, th_high_q;
    logic                 ovf_d, ovf_q;
    logic                 udf_d, udf_q;

    logic running, accepting, flush;
    logic full, empty, wr_en, rd_en, ovf_evt, udf_evt;

    // A request coinciding with init is dropped in favour of the flush.
    assign running   = (state_q == StIdle) || (state_q == StActive);
    assign accepting = running && !bus.init;
    assign flush     = running && bus.init;

    assign full  = (count_q == CNT_WIDTH'(DEPTH));
    assign empty = (count_q == '0);

    assign wr_en   = bus.push && !full && accepting;
    assign rd_en   = bus.pop && !empty && accepting;
    assign ovf_evt = bus.push && full && accepting;
    assign udf_evt = bus.pop && empty && accepting;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (wr_en && !rd_en) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: state_d = StInit;
            StInit: begin
                if (!bus.init) state_d = StIdle;
            end
            StIdle, StActive: begin
                if (bus.init) begin
                    state_d = StInit;
                end else if (ovf_evt || udf_evt) begin
                    state_d = StError;
                end else if (state_q == StIdle && wr_en) begin
                    state_d = StActive;
                end else if (state_q == StActive && rd_en && !wr_en &&
                             count_q == CNT_WIDTH'(1)) begin
                    state_d = StIdle;
                end
            end
            StError: state_d = StError;
            default: state_d = StReset;
        endcase
    end

    assign th_low_d  = (state_q == StInit && bus.init) ? bus.th_low : th_low_q;
    assign th_high_d = (state_q == StInit && bus.init) ? bus.th_high : th_high_q;
    assign ovf_d     = ovf_q || ovf_evt;
    assign udf_d     = udf_q || udf_evt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StReset;
            count_q   <= '0;
            th_low_q  <= CNT_WIDTH'(TH_LOW_DEF);
            th_high_q <= CNT_WIDTH'(TH_HIGH_DEF);
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            th_low_q  <= th_low_d;
            th_high_q <= th_high_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    fifo_ptr #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_wr_ptr (
        .clk     (clk),
        .reset   (reset),
        .en_i    (wr_en),
        .flush_i (flush),
        .ptr_o   (bus.wr_ptr)
    );

    fifo_ptr #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rd_ptr (
        .clk     (clk),
        .reset   (reset),
        .en_i    (rd_en),
        .flush_i (flush),
        .ptr_o   (bus.rd_ptr)
    );

    assign bus.wr_enable     = wr_en;
    assign bus.rd_enable     = rd_en;
    assign bus.count         = count_q;
    assign bus.full          = full;
    assign bus.empty         = empty;
    assign bus.almost_full   = (count_q >= th_high_q);
    assign bus.almost_empty  = (count_q <= th_low_q);
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = udf_q;
    assign bus.state         = state_q;

endmodule
